tag_reorder_buffer: RTL and testbench

- Tag allocator plus in-order retirement queue. It sits downstream of the request-issue stage and on the response path of the tag-based memory/unit interface.
- Each issued request takes a tag in program order. Responses return out of order, keyed by tag. The block emits them strictly in allocation order over a valid/ready output and frees each tag on retirement.

---
 rtl/tag_reorder_buffer_if.sv | 36 +++
 rtl/tag_reorder_buffer.sv | 106 ++++++++++
 tb/tb_tag_reorder_buffer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_reorder_buffer_if.sv
// Handshake and status bundle between a tag reorder buffer and its environment.
// Latency: none, plain wires.
// Backpressure: carried by alloc_ready (tag availability) and out_ready (consumer).
interface tag_reorder_buffer_if #(
  parameter int DATAW = 32,
  parameter int ADDRW = 3
);
  logic             alloc_valid;
  logic             alloc_ready;
  logic [ADDRW-1:0] alloc_tag;

  logic             fill_valid;
  logic [ADDRW-1:0] fill_tag;
  logic [DATAW-1:0] fill_data;

  logic             out_valid;
  logic [ADDRW-1:0] out_tag;
  logic [DATAW-1:0] out_data;
  logic             out_ready;

  logic             empty;
  logic             full;
  logic [ADDRW:0]   count;

  // Environment side: issues allocs and fills, consumes retired responses.
  modport master (
    output alloc_valid, fill_valid, fill_tag, fill_data, out_ready,
    input  alloc_ready, alloc_tag, out_valid, out_tag, out_data, empty, full, count
  );

  // Buffer side.
  modport slave (
    input  alloc_valid, fill_valid, fill_tag, fill_data, out_ready,
    output alloc_ready, alloc_tag, out_valid, out_tag, out_data, empty, full, count
  );
endinterface

// File: rtl/tag_reorder_buffer.sv
// Tag allocator that retires out-of-order responses strictly in allocation order.
// Latency: alloc_tag valid in the handshake cycle; fill to out_valid is one cycle minimum.
// Backpressure: alloc_ready low while all tags are outstanding; head held stable until out_ready.
module tag_reorder_buffer #(
  parameter  int DATAW = 32,
  parameter  int SIZE  = 8,
  localparam int ADDRW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                clk,
  input  logic                reset,
  tag_reorder_buffer_if.slave bus
);

  localparam logic [ADDRW-1:0] LAST   = ADDRW'(SIZE - 1);
  localparam logic [ADDRW:0]   SIZE_W = (ADDRW + 1)'(SIZE);

  logic [ADDRW-1:0] head;
  logic [ADDRW-1:0] tail;
  logic [ADDRW:0]   cnt;
  logic [SIZE-1:0]  busy;
  logic [SIZE-1:0]  done;
  logic [DATAW-1:0] mem [SIZE];

  logic full_w;
  logic empty_w;
  logic out_valid_w;
  logic alloc_hs;
  logic retire_hs;
  logic fill_in_range;
  logic fill_ok;

  // Pointers wrap explicitly so SIZE need not be a power of two.
  function automatic logic [ADDRW-1:0] next_ptr(input logic [ADDRW-1:0] p);
    return (p == LAST) ? '0 : p + ADDRW'(1);
  endfunction

  // Status is decoded from registered state only, so there is no fill-to-output
  // combinational path and a retire cannot free a slot for the same cycle's alloc.
  assign full_w      = (cnt == SIZE_W);
  assign empty_w     = (cnt == '0);
  assign out_valid_w = busy[head] && done[head];
  assign alloc_hs    = bus.alloc_valid && !full_w;
  assign retire_hs   = out_valid_w && bus.out_ready;

  // A fill is accepted only for an outstanding slot that has not yet been filled;
  // anything else (free slot, duplicate, out-of-range tag) leaves state untouched.
  assign fill_in_range = ({1'b0, bus.fill_tag} < SIZE_W);
  assign fill_ok       = bus.fill_valid && fill_in_range &&
                         busy[bus.fill_tag] && !done[bus.fill_tag];

  assign bus.alloc_ready = !full_w;
  assign bus.alloc_tag   = tail;
  assign bus.out_valid   = out_valid_w;
  assign bus.out_tag     = head;
  assign bus.out_data    = mem[head];
  assign bus.empty       = empty_w;
  assign bus.full        = full_w;
  assign bus.count       = cnt;

  // Pointer, occupancy and per-slot status updates; alloc, fill and retire never
  // target the same slot in one cycle, so their writes are independent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      busy <= '0;
      done <= '0;
    end else begin
      if (alloc_hs) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        tail       <= next_ptr(tail);
      end
      if (fill_ok) begin
        done[bus.fill_tag] <= 1'b1;
      end
      if (retire_hs) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head       <= next_ptr(head);
      end
      case ({alloc_hs, retire_hs})
        2'b10:   cnt <= cnt + (ADDRW + 1)'(1);
        2'b01:   cnt <= cnt - (ADDRW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage; written only by accepted fills and never reset.
  always_ff @(posedge clk) begin
    if (fill_ok) begin
      mem[bus.fill_tag] <= bus.fill_data;
    end
  end

  // Flag fills that were dropped because their slot was free, already filled or out of range.
  always @(posedge clk) begin
    if (reset && bus.fill_valid) begin
      assert (fill_ok)
        else $warning("tag_reorder_buffer: dropped fill to tag %0d", bus.fill_tag);
    end
  end

endmodule

// File: tb/tb_tag_reorder_buffer.sv
// Randomised and directed checks of tag_reorder_buffer at SIZE=8 and SIZE=5.
// Latency: n/a.
// Backpressure: out_ready is randomised and held low in directed phases.
module tb_tag_reorder_buffer;
  localparam int DW = 32;
  localparam int AW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tag_reorder_buffer_if #(.DATAW(DW), .ADDRW(AW)) if8 ();
  tag_reorder_buffer_if #(.DATAW(DW), .ADDRW(AW)) if5 ();

  tag_reorder_buffer #(.DATAW(DW), .SIZE(8)) u_dut8 (.clk(clk), .reset(rst_n), .bus(if8.slave));
  tag_reorder_buffer #(.DATAW(DW), .SIZE(5)) u_dut5 (.clk(clk), .reset(rst_n), .bus(if5.slave));

  // Reference model: per DUT, a queue of outstanding tags in allocation order plus
  // which of them have received their response and with what payload.
  int unsigned   ord_q   [2][$];
  bit            filled  [2][8];
  logic [DW-1:0] fdat    [2][8];
  int unsigned   alloc_n [2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got 0x%0h, expected 0x%0h", d, nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ord_q[d].delete();
      alloc_n[d] = 0;
      for (int t = 0; t < 8; t++) filled[d][t] = 1'b0;
    end
  endtask

  // Check one cycle of DUT outputs against the model, then apply that cycle's handshakes.
  task automatic mon_step(input int d, input int unsigned sz,
                          input logic av, input logic ar, input logic [AW-1:0] atag,
                          input logic fv, input logic [AW-1:0] ftag, input logic [DW-1:0] fd,
                          input logic ov, input logic [AW-1:0] otag, input logic [DW-1:0] od,
                          input logic ordy, input logic em, input logic fu, input logic [AW:0] cnt);
    int unsigned n;
    int unsigned head_tag;
    int unsigned tail_tag;
    int unsigned ft;
    bit exp_ov;
    bit legal;
    n        = ord_q[d].size();
    tail_tag = alloc_n[d] % sz;
    head_tag = tail_tag;
    exp_ov   = 1'b0;
    if (n > 0) begin
      head_tag = ord_q[d][0];
      exp_ov   = filled[d][head_tag];
    end
    chk(d, "count",       64'(cnt),  64'(n));
    chk(d, "empty",       64'(em),   64'(n == 0));
    chk(d, "full",        64'(fu),   64'(n == sz));
    chk(d, "alloc_ready", 64'(ar),   64'(n < sz));
    chk(d, "alloc_tag",   64'(atag), 64'(tail_tag));
    chk(d, "out_valid",   64'(ov),   64'(exp_ov));
    chk(d, "out_tag",     64'(otag), 64'(head_tag));
    if (exp_ov) chk(d, "out_data", 64'(od), 64'(fdat[d][head_tag]));

    ft    = 32'(ftag);
    legal = 1'b0;
    if (fv && ft < sz && !filled[d][ft]) begin
      for (int i = 0; i < int'(n); i++) if (ord_q[d][i] == ft) legal = 1'b1;
    end
    if (legal) begin
      filled[d][ft] = 1'b1;
      fdat[d][ft]   = fd;
    end
    if (exp_ov && ordy) begin
      filled[d][head_tag] = 1'b0;
      void'(ord_q[d].pop_front());
    end
    if (av && n < sz) begin
      ord_q[d].push_back(tail_tag);
      filled[d][tail_tag] = 1'b0;
      alloc_n[d]++;
    end
  endtask

  // Monitor: samples both DUTs on the falling edge, away from state updates.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        mon_step(0, 8, if8.alloc_valid, if8.alloc_ready, if8.alloc_tag, if8.fill_valid, if8.fill_tag,
                 if8.fill_data, if8.out_valid, if8.out_tag, if8.out_data, if8.out_ready,
                 if8.empty, if8.full, if8.count);
        mon_step(1, 5, if5.alloc_valid, if5.alloc_ready, if5.alloc_tag, if5.fill_valid, if5.fill_tag,
                 if5.fill_data, if5.out_valid, if5.out_tag, if5.out_data, if5.out_ready,
                 if5.empty, if5.full, if5.count);
      end
    end
  end

  task automatic set_in(input int d, input int av, input int fv, input int ft,
                        input logic [DW-1:0] fd, input int ordy);
    if (d == 0) begin
      if8.alloc_valid = (av != 0);
      if8.fill_valid  = (fv != 0);
      if8.fill_tag    = AW'(ft);
      if8.fill_data   = fd;
      if8.out_ready   = (ordy != 0);
    end else begin
      if5.alloc_valid = (av != 0);
      if5.fill_valid  = (fv != 0);
      if5.fill_tag    = AW'(ft);
      if5.fill_data   = fd;
      if5.out_ready   = (ordy != 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1: asserts reset mid-cycle and releases it after the next edge.
  task automatic async_rst();
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pick_fill(input int d, output bit ok, output int t);
    int unsigned cand[$];
    for (int i = 0; i < ord_q[d].size(); i++)
      if (!filled[d][ord_q[d][i]]) cand.push_back(ord_q[d][i]);
    ok = (cand.size() > 0);
    t  = 0;
    if (ok) t = int'(cand[$urandom_range(0, cand.size() - 1)]);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int bp [4];
    int pa, ft, fv;
    bit ok;

    set_in(0, 0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk(0, "rst_out_valid",   64'(if8.out_valid),   64'(0));
    chk(0, "rst_empty",       64'(if8.empty),       64'(1));
    chk(0, "rst_full",        64'(if8.full),        64'(0));
    chk(0, "rst_alloc_ready", 64'(if8.alloc_ready), 64'(1));
    chk(0, "rst_count",       64'(if8.count),       64'(0));

    // In-order retirement of out-of-order fills.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, 0, 0, 1);
      #1 chk(0, "t1_alloc_tag", 64'(if8.alloc_tag), 64'(i));
      tick();
    end
    set_in(0, 0, 1, 2, 32'hC, 1); tick();
    set_in(0, 0, 1, 0, 32'hA, 1);
    #1 chk(0, "t1_no_comb_valid", 64'(if8.out_valid), 64'(0));
    tick();
    chk(0, "t1_valid_next", 64'(if8.out_valid), 64'(1));
    chk(0, "t1_first_data", 64'(if8.out_data),  64'(32'hA));
    set_in(0, 0, 1, 1, 32'hB, 1); tick();
    chk(0, "t1_second_tag", 64'(if8.out_tag), 64'(1));
    set_in(0, 0, 0, 0, 0, 1);
    repeat (3) tick();
    chk(0, "t1_empty_end", 64'(if8.empty), 64'(1));

    // Full, refused alloc, and no same-cycle reuse of a retiring slot.
    async_rst();
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1, 0, 0, 0, 0); tick();
    end
    set_in(0, 1, 0, 0, 0, 0);
    #1;
    chk(0, "t2_full",        64'(if8.full),        64'(1));
    chk(0, "t2_alloc_ready", 64'(if8.alloc_ready), 64'(0));
    chk(0, "t2_count",       64'(if8.count),       64'(8));
    tick();
    chk(0, "t2_tail_stays",  64'(if8.alloc_tag),   64'(0));
    set_in(0, 1, 1, 0, 32'h5A5A, 0); tick();
    set_in(0, 1, 0, 0, 0, 1);
    #1 chk(0, "t2_no_bypass", 64'(if8.alloc_ready), 64'(0));
    tick();
    set_in(0, 1, 0, 0, 0, 0);
    #1 chk(0, "t2_regrant_ready", 64'(if8.alloc_ready), 64'(1));
    chk(0, "t2_regrant_tag", 64'(if8.alloc_tag), 64'(0));
    tick();
    chk(0, "t2_full_again", 64'(if8.full), 64'(1));
    for (int t = 1; t < 8; t++) begin
      set_in(0, 0, 1, t, $urandom, 1); tick();
    end
    set_in(0, 0, 1, 0, $urandom, 1); tick();
    set_in(0, 0, 0, 0, 0, 1);
    repeat (10) tick();
    chk(0, "t2_empty_end", 64'(if8.empty), 64'(1));

    // Backpressure: head held while other fills land, then drain one per cycle.
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 0, 0, 0, 0); tick();
    end
    for (int i = 0; i < 4; i++) bp[i] = int'(ord_q[0][i]);
    set_in(0, 0, 1, bp[0], 32'h1000, 0); tick();
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, (k < 3) ? 1 : 0, (k < 3) ? bp[k + 1] : 0, 32'h1001 + k, 0);
      #1;
      chk(0, "bp_hold_valid", 64'(if8.out_valid), 64'(1));
      chk(0, "bp_hold_tag",   64'(if8.out_tag),   64'(bp[0]));
      chk(0, "bp_hold_data",  64'(if8.out_data),  64'(32'h1000));
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 0, 0, 0, 1);
      #1;
      chk(0, "bp_drain_valid", 64'(if8.out_valid), 64'(1));
      chk(0, "bp_drain_tag",   64'(if8.out_tag),   64'(bp[k]));
      chk(0, "bp_drain_data",  64'(if8.out_data),  64'(32'h1000 + k));
      tick();
    end
    chk(0, "bp_empty_end", 64'(if8.empty), 64'(1));

    // Asynchronous reset with tags outstanding and the head valid.
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 0, 0, 0, 0); tick();
    end
    set_in(0, 0, 1, int'(ord_q[0][0]), 32'h77, 0); tick();
    set_in(0, 0, 0, 0, 0, 0);
    chk(0, "ar_pre_valid", 64'(if8.out_valid), 64'(1));
    #2 rst_n = 1'b0;
    set_in(0, 0, 1, 3, 32'hEE, 0);
    #1;
    chk(0, "ar_valid",       64'(if8.out_valid),   64'(0));
    chk(0, "ar_empty",       64'(if8.empty),       64'(1));
    chk(0, "ar_count",       64'(if8.count),       64'(0));
    chk(0, "ar_alloc_ready", 64'(if8.alloc_ready), 64'(1));
    chk(0, "ar_out_tag",     64'(if8.out_tag),     64'(0));
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_in(0, 1, 0, 0, 0, 0);
    #1 chk(0, "ar_first_tag", 64'(if8.alloc_tag), 64'(0));
    tick();

    // Illegal fills: free tag 6, then a duplicate to tag 1.
    set_in(0, 1, 0, 0, 0, 0); tick();
    set_in(0, 1, 0, 0, 0, 0); tick();
    set_in(0, 0, 1, 6, 32'h66, 0); tick();
    set_in(0, 0, 1, 1, 32'hB1, 0); tick();
    set_in(0, 0, 1, 1, 32'hFF, 0); tick();
    set_in(0, 0, 1, 0, 32'hA0, 0); tick();
    set_in(0, 0, 1, 2, 32'hC2, 1);
    #1 chk(0, "ill_tag0_data", 64'(if8.out_data), 64'(32'hA0));
    tick();
    set_in(0, 0, 0, 0, 0, 1);
    #1;
    chk(0, "ill_tag1_tag",  64'(if8.out_tag),  64'(1));
    chk(0, "ill_tag1_data", 64'(if8.out_data), 64'(32'hB1));
    repeat (3) tick();
    chk(0, "ill_empty_end", 64'(if8.empty), 64'(1));
    set_in(0, 0, 0, 0, 0, 0);

    // SIZE=5 wrap, including an out-of-range fill tag.
    for (int i = 0; i < 12; i++) begin
      set_in(1, 1, 0, 0, 0, 1);
      #1 chk(1, "wrap_alloc_tag", 64'(if5.alloc_tag), 64'(i % 5));
      tick();
      if (i == 3) begin
        set_in(1, 0, 1, 7, 32'hDEAD, 0); tick();
      end
      set_in(1, 0, 1, i % 5, 32'h500 + i, 1); tick();
      set_in(1, 0, 0, 0, 0, 1);
      #1;
      chk(1, "wrap_out_tag",  64'(if5.out_tag),  64'(i % 5));
      chk(1, "wrap_out_data", 64'(if5.out_data), 64'(32'h500 + i));
      tick();
    end
    set_in(1, 0, 0, 0, 0, 0);

    // Random traffic on both instances, with an asynchronous reset halfway.
    for (int c = 0; c < 2000; c++) begin
      for (int d = 0; d < 2; d++) begin
        pa = (((c / 200) % 2) != 0) ? 85 : 40;
        pick_fill(d, ok, ft);
        fv = (ok && $urandom_range(0, 99) < 60) ? 1 : 0;
        if ($urandom_range(0, 99) < 5) begin
          fv = 1;
          ft = int'($urandom_range(0, 7));
        end
        set_in(d, ($urandom_range(0, 99) < pa) ? 1 : 0, fv, ft, $urandom,
               ($urandom_range(0, 99) < 70) ? 1 : 0);
      end
      if (c == 1000) async_rst();
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
